lru_controller: RTL
===================

LRU_CONTROLLER -- requirements
Module: lru_controller

Interface
REQ-001 The module SHALL have parameter WAYS, default 16, meaning number of ways tracked (power of two, 2..64).
REQ-002 The module SHALL have parameter TICK_WIDTH, default 32, meaning width of the per-way timestamp and of the global counter.
REQ-003 The module SHALL have parameter KEY_WIDTH, default $clog2(WAYS), meaning width of a way index.
REQ-004 The module SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port resetn  input  1  meaning reset, synchronous and active-low.
REQ-006 The module SHALL have port touch_valid  input  1  meaning an access (hit or fill) to touch_way is requested.
REQ-007 The module SHALL have port touch_way  input  KEY_WIDTH  meaning the accessed way.
REQ-008 The module SHALL have port touch_ready  output  1  meaning a touch is accepted this cycle; it is low during HALVE.
REQ-009 The module SHALL have port inv_valid  input  1  meaning invalidate inv_way; it is always accepted.
REQ-010 The module SHALL have port inv_way  input  KEY_WIDTH  meaning the way to invalidate.
REQ-011 The module SHALL have port victim_req  input  1  meaning a victim is requested.
REQ-012 The module SHALL have port victim_valid  output  1  meaning victim_way is valid this cycle.
REQ-013 The module SHALL have port victim_way  output  KEY_WIDTH  meaning the selected least-recently-used way.

Function
REQ-014 State: tick[0..WAYS-1] (TICK_WIDTH each), counter (TICK_WIDTH), FSM {IDLE, HALVE}, halve index (KEY_WIDTH), victim registers.
REQ-015 Touch is accepted when touch_valid && touch_ready; then tick[touch_way] <= counter and counter <= counter+1.
REQ-016 Invalidate: tick[inv_way] <= 0 in any state, including HALVE.
REQ-017 Same-cycle touch and invalidate on the same way: invalidate wins, the touch is dropped and counter does not increment, but touch_ready still reads high.
REQ-018 Victim selection: argmin over the registered tick[] (pre-update values for the current cycle); ties resolve to the lowest index.
REQ-019 Victim latency: victim_req in IDLE at cycle N gives victim_valid=1 and victim_way at N+1, both held exactly one cycle.
REQ-020 victim_req while in HALVE SHALL be held off: it is latched and answered one cycle after the return to IDLE, with no request lost.
REQ-021 Wrap: an accepted touch while counter == 2^TICK_WIDTH-1 writes that tick and moves the FSM to HALVE with index 0.
REQ-022 HALVE: each cycle tick[index] <= tick[index] >> 1 and index increments; after index WAYS-1 the FSM returns to IDLE, taking WAYS cycles total.
REQ-023 On entry to HALVE, counter <= 2^(TICK_WIDTH-1), which is strictly greater than any halved tick.
REQ-024 Relative order is preserved non-strictly by HALVE; equal ticks created by HALVE follow REQ-018.
REQ-025 touch_ready = (state == IDLE); there is no combinational path from inputs to touch_ready.
REQ-026 An invalidate during HALVE to an already-halved or not-yet-halved way leaves that tick at 0.

Reset
REQ-027 When resetn is low at a clock edge: all ticks are 0, counter is 1, state is IDLE, index is 0, victim_valid is 0, victim_way is 0, and any pending victim request is cleared.
REQ-028 Reset mid-HALVE aborts the sweep; touch_ready is 1 on the first cycle after resetn rises.

Structure
REQ-029 A shared package lru_pkg SHALL hold the FSM state enum (IDLE, HALVE) and the tick_t typedef helper.
REQ-030 One sub-module, lru_argmin, SHALL implement the combinational argmin tree (recursive halves; compare with <=, left wins on tie). All sequential logic lives in lru_controller.

Verification (WAYS=4, TICK_WIDTH=4 unless noted)
REQ-031 Reset, then victim_req -> next cycle victim_valid=1, victim_way=0; touch_ready=1.
REQ-032 Touch ways 0,1,2,3 then 0 (ticks 1..5), then victim_req -> victim_way=1.
REQ-033 From REQ-032, inv way 2 and in the same cycle touch way 2 -> tick[2]=0 and counter unchanged at 6; victim_req -> victim_way=2.
REQ-034 Touch until counter=15, touch way 3 -> touch_ready low for exactly 4 cycles; ticks are halved; counter=8; victim_req raised during HALVE is answered one cycle after IDLE with the correct argmin.
REQ-035 Assert resetn low at HALVE cycle 2 -> all ticks 0, counter 1, touch_ready=1 the cycle after release, and no stale victim_valid.
REQ-036 Random touch/inv/victim stream (WAYS=16, TICK_WIDTH=6) checked against a reference-model LRU order, with the tie rule of REQ-018.

Source files
------------

// File: rtl/lru_pkg.sv
// Shared types for the timestamp-based LRU controller.
package lru_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    HALVE = 1'b1
  } lru_state_e;

  // Widest supported timestamp; per-instance ticks are truncated views of this.
  localparam int TICK_MAX_W = 64;
  typedef logic [TICK_MAX_W-1:0] tick_t;

endpackage

// File: rtl/lru_argmin.sv
// Combinational argmin over N timestamps, built as a recursive tree of halves.
// Ties go to the left half, so the lowest index wins overall.
module lru_argmin #(
  parameter int N = 16,
  parameter int W = 32
) (
  input  logic [N-1:0][W-1:0]   vals_i,
  output logic [$clog2(N)-1:0]  idx_o
);

  generate
    if (N == 2) begin : g_leaf
      assign idx_o = (vals_i[0] <= vals_i[1]) ? 1'b0 : 1'b1;
    end else begin : g_node
      localparam int H  = N / 2;
      localparam int CW = $clog2(H);

      logic [H-1:0][W-1:0] l_vals, r_vals;
      logic [CW-1:0]       l_idx, r_idx;
      logic [W-1:0]        l_min, r_min;

      assign l_vals = vals_i[H-1:0];
      assign r_vals = vals_i[N-1:H];

      lru_argmin #(.N(H), .W(W)) u_l (.vals_i(l_vals), .idx_o(l_idx));
      lru_argmin #(.N(H), .W(W)) u_r (.vals_i(r_vals), .idx_o(r_idx));

      assign l_min = l_vals[l_idx];
      assign r_min = r_vals[r_idx];
      // The top index bit selects the half, so no offset add is needed.
      assign idx_o = (l_min <= r_min) ? {1'b0, l_idx} : {1'b1, r_idx};
    end
  endgenerate

endmodule

// File: rtl/lru_controller.sv
// Timestamp LRU tracker: per-way ticks, victim = oldest tick; a counter wrap
// triggers a one-way-per-cycle halving sweep so order survives the wrap.
module lru_controller
  import lru_pkg::*;
#(
  parameter int WAYS       = 16,
  parameter int TICK_WIDTH = 32,
  parameter int KEY_WIDTH  = $clog2(WAYS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 touch_valid,
  input  logic [KEY_WIDTH-1:0] touch_way,
  output logic                 touch_ready,
  input  logic                 inv_valid,
  input  logic [KEY_WIDTH-1:0] inv_way,
  input  logic                 victim_req,
  output logic                 victim_valid,
  output logic [KEY_WIDTH-1:0] victim_way
);

  typedef logic [TICK_WIDTH-1:0] tk_t;

  localparam tk_t TICK_MAX  = '1;
  localparam tk_t HALF_BASE = tk_t'(tick_t'(1) << (TICK_WIDTH - 1));

  lru_state_e                     state_q, state_d;
  logic [WAYS-1:0][TICK_WIDTH-1:0] ticks_q, ticks_d;
  tk_t                            cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0]           idx_q, idx_d;
  logic                           vvalid_q, vvalid_d;
  logic [KEY_WIDTH-1:0]           vway_q, vway_d;
  logic                           pend_q, pend_d;

  logic                           touch_acc;
  logic [$clog2(WAYS)-1:0]        argmin_idx;

  lru_argmin #(.N(WAYS), .W(TICK_WIDTH)) u_argmin (
    .vals_i (ticks_q),
    .idx_o  (argmin_idx)
  );

  assign touch_ready  = (state_q == IDLE);
  // A colliding invalidate swallows the touch, but ready stays registered-only.
  assign touch_acc    = touch_valid && touch_ready && !(inv_valid && (inv_way == touch_way));
  assign victim_valid = vvalid_q;
  assign victim_way   = vway_q;

  always_comb begin
    ticks_d  = ticks_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    idx_d    = idx_q;
    vvalid_d = 1'b0;
    vway_d   = vway_q;
    pend_d   = pend_q;

    if (state_q == IDLE) begin
      if (victim_req || pend_q) begin
        vvalid_d = 1'b1;
        vway_d   = KEY_WIDTH'(argmin_idx);
        pend_d   = 1'b0;
      end
      if (touch_acc) begin
        ticks_d[touch_way] = cnt_q;
        if (cnt_q == TICK_MAX) begin
          cnt_d   = HALF_BASE;
          state_d = HALVE;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else begin
      if (victim_req) pend_d = 1'b1;
      ticks_d[idx_q] = ticks_q[idx_q] >> 1;
      idx_d          = idx_q + 1'b1;
      if (idx_q == KEY_WIDTH'(WAYS - 1)) begin
        state_d = IDLE;
        idx_d   = '0;
      end
    end

    if (inv_valid) ticks_d[inv_way] = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ticks_q  <= '0;
      cnt_q    <= tk_t'(1);
      state_q  <= IDLE;
      idx_q    <= '0;
      vvalid_q <= 1'b0;
      vway_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      ticks_q  <= ticks_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      vvalid_q <= vvalid_d;
      vway_q   <= vway_d;
      pend_q   <= pend_d;
    end
  end

endmodule
